usb_ep_tx_packetizer: RTL and testbench
=======================================

Name: usb_ep_tx_packetizer

Overview:
- Sits directly downstream of the endpoint transaction FIFO's pop side.
- On an IN token for its endpoint, it pulls bytes from the FIFO and frames them for the packet transmitter as one data packet: PID byte first, then payload, then an end-of-packet strobe. The transmitter appends the CRC.
- It then waits for the host handshake. ACK commits the FIFO pop transaction and advances the data toggle. A timeout or non-ACK rolls the pop back so the identical packet is resent on retry.

Parameters:
- MAX_PACKET_SIZE, 64: maximum payload bytes per packet (1..1023).
- IS_ISOCHRONOUS, 0: 1 means no handshake phase and the PID is always DATA0.

Ports:
- clk12_i  in  1  12 MHz clock; the only clock.
- rst_i  in  1  synchronous, active-high reset.
- txReq_i  in  1  single-cycle pulse: IN token addressed to this endpoint.
- resetDataToggle_i  in  1  configuration event; forces the toggle to DATA0.
- EP_dataAvailable_i  in  1  FIFO head byte is valid.
- EP_data_i  in  8  FIFO head byte.
- EP_popData_o  out  1  pop the head byte.
- EP_popTransDone_o  out  1  single-cycle pulse: end of pop transaction.
- EP_popTransSuccess_o  out  1  qualifies EP_popTransDone_o: 1 = commit, 0 = rollback.
- txValid_o  out  1  txData_o is valid.
- txData_o  out  8  byte to the transmitter.
- txReady_i  in  1  transmitter accepts the byte when txValid_o && txReady_i.
- txEop_o  out  1  single-cycle pulse: packet payload complete.
- hsValid_i  in  1  single-cycle pulse: host handshake received.
- hsIsAck_i  in  1  with hsValid_i: 1 = ACK.
- hsTimeout_i  in  1  single-cycle pulse: handshake timeout expired.
- busy_o  out  1  state is not IDLE.
- dataToggle_o  out  1  current expected toggle (0 = DATA0).

Behaviour:
- Reset:
  - State IDLE, toggle 0, byte counter 0.
  - All outputs 0; txData_o = 0x00.
  - No pop-transaction pulse is emitted. The FIFO's own reset discards uncommitted reads.
  - Reset takes priority over every other input.
- States: IDLE, SEND_PID, SEND_DATA, SEND_EOP, WAIT_HS.
- IDLE:
  - txReq_i moves to SEND_PID on the next cycle.
  - txReq_i in any other state is ignored.
- SEND_PID:
  - txValid_o = 1; txData_o = 0xC3 if toggle = 0 (DATA0), 0x4B if toggle = 1 (DATA1).
  - Isochronous mode always sends 0xC3.
  - Holds until txReady_i, then goes to SEND_DATA and clears the counter.
- SEND_DATA:
  - txValid_o = EP_dataAvailable_i && (cnt < MAX_PACKET_SIZE); txData_o = EP_data_i (combinational pass-through).
  - EP_popData_o = txValid_o && txReady_i. Each accepted byte increments cnt, width $clog2(MAX_PACKET_SIZE+1).
  - Goes to SEND_EOP when EP_dataAvailable_i = 0, or when cnt reaches MAX_PACKET_SIZE.
  - Reaching the limit with data still available ends the packet; the remaining bytes stay in the FIFO for the next transaction.
  - An empty FIFO on entry produces a zero-length packet.
- SEND_EOP:
  - txEop_o = 1 for exactly one cycle.
  - Non-isochronous: next state WAIT_HS.
  - Isochronous: same cycle pulses EP_popTransDone_o = 1 and EP_popTransSuccess_o = 1; next state IDLE; toggle unchanged.
- WAIT_HS:
  - hsValid_i && hsIsAck_i: pulse PopTransDone with Success = 1, flip the toggle, go to IDLE.
  - hsValid_i && !hsIsAck_i, or hsTimeout_i: pulse PopTransDone with Success = 0 (rollback), toggle unchanged, go to IDLE.
  - hsValid_i and hsTimeout_i in the same cycle: hsValid_i wins.
- Pulse timing:
  - PopTransDone/Success are asserted in the cycle after the qualifying input.
  - The state machine is in IDLE in that same cycle, so a txReq_i one cycle later is legal.
- Data toggle:
  - resetDataToggle_i clears the toggle in any state, effective next cycle, and wins over a simultaneous ACK flip.
  - It does not abort an in-flight packet; the PID already sent is unaffected.
- busy_o = (state != IDLE).
- dataToggle_o is the registered toggle.

Test Plan:
- 3 bytes 0x11, 0x22, 0x33 in FIFO, txReq_i, txReady_i = 1, then ACK -> stream 0xC3, 0x11, 0x22, 0x33; txEop_o one cycle; exactly 3 pops; commit pulse with Success = 1; dataToggle_o = 1. A second identical transaction starts with PID 0x4B.
- Empty FIFO, txReq_i, ACK -> PID 0xC3 only, zero pops, txEop_o, commit pulse.
- MAX_PACKET_SIZE = 64 with 70 bytes queued -> exactly 64 payload bytes then EOP; 6 bytes remain available; ACK commits.
- 2 bytes, hsTimeout_i -> rollback pulse (Success = 0), toggle stays 0. Retry resends 0xC3 and the same 2 bytes.
- txReady_i low for 3 cycles mid-payload -> txValid_o/txData_o held stable, no extra pops, byte order preserved.
- resetDataToggle_i in the same cycle as ACK while toggle = 1 -> toggle = 0.
- IS_ISOCHRONOUS = 1 -> two consecutive packets both use 0xC3, auto-commit at EOP, hs inputs ignored.
- rst_i asserted in SEND_DATA -> next cycle busy_o = 0, all outputs 0, no PopTransDone pulse.

Source files
------------

// File: rtl/usb_ep_tx_packetizer.sv
// usb_ep_tx_packetizer
//
// Frames one USB data packet per IN token from the endpoint FIFO's pop side.
// The packet goes out as the PID byte, then the payload bytes, then a one-cycle
// end-of-packet strobe. The transmitter appends the CRC. In non-isochronous
// mode the block then waits for the host handshake. An ACK commits the FIFO
// pop transaction and advances the data toggle. A NAK or a timeout rolls the
// pop back, so a retry resends an identical packet.
//
// Ports
//   clk12_i               12 MHz clock
//   rst_i                 synchronous active-high reset
//   txReq_i               IN token for this endpoint (pulse)
//   resetDataToggle_i     force the data toggle back to DATA0
//   EP_dataAvailable_i    FIFO head byte valid
//   EP_data_i[7:0]        FIFO head byte
//   EP_popData_o          pop the FIFO head byte
//   EP_popTransDone_o     end of pop transaction (pulse)
//   EP_popTransSuccess_o  with EP_popTransDone_o: 1 = commit, 0 = rollback
//   txValid_o/txData_o    byte stream to the transmitter
//   txReady_i             transmitter accepts the byte
//   txEop_o               payload complete (pulse)
//   hsValid_i/hsIsAck_i   host handshake received / handshake is ACK
//   hsTimeout_i           handshake timeout (pulse)
//   busy_o                packet or handshake in progress
//   dataToggle_o          current data toggle (0 = DATA0)

module usb_ep_tx_packetizer #(
  parameter int MAX_PACKET_SIZE = 64,
  parameter bit IS_ISOCHRONOUS  = 1'b0
) (
  input  logic       clk12_i,
  input  logic       rst_i,
  input  logic       txReq_i,
  input  logic       resetDataToggle_i,
  input  logic       EP_dataAvailable_i,
  input  logic [7:0] EP_data_i,
  output logic       EP_popData_o,
  output logic       EP_popTransDone_o,
  output logic       EP_popTransSuccess_o,
  output logic       txValid_o,
  output logic [7:0] txData_o,
  input  logic       txReady_i,
  output logic       txEop_o,
  input  logic       hsValid_i,
  input  logic       hsIsAck_i,
  input  logic       hsTimeout_i,
  output logic       busy_o,
  output logic       dataToggle_o
);

  localparam int              CNT_W     = $clog2(MAX_PACKET_SIZE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_PACKET_SIZE);
  localparam logic [7:0]      PID_DATA0 = 8'hC3;
  localparam logic [7:0]      PID_DATA1 = 8'h4B;

  typedef enum logic [2:0] {
    IDLE,
    SEND_PID,
    SEND_DATA,
    SEND_EOP,
    WAIT_HS
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             toggle;
  logic             done_pulse;
  logic             success_flag;

  logic             room;
  logic             data_valid;
  logic             accept;

  // Payload bytes are offered only while the packet still has room. Bytes
  // left in the FIFO after the limit belong to the next transaction.
  assign room       = (cnt < CNT_MAX);
  assign data_valid = EP_dataAvailable_i && room;
  assign accept     = data_valid && txReady_i;

  assign busy_o       = (state != IDLE);
  assign dataToggle_o = toggle;

  // Stream outputs are decoded from the state. All of them are forced low
  // while reset is asserted, so nothing is popped or committed on the reset
  // edge. The FIFO's own reset discards the uncommitted reads.
  always_comb begin
    txValid_o            = 1'b0;
    txData_o             = 8'h00;
    EP_popData_o         = 1'b0;
    txEop_o              = 1'b0;
    EP_popTransDone_o    = done_pulse;
    EP_popTransSuccess_o = success_flag;
    if (rst_i) begin
      EP_popTransDone_o    = 1'b0;
      EP_popTransSuccess_o = 1'b0;
    end else begin
      case (state)
        SEND_PID: begin
          txValid_o = 1'b1;
          txData_o  = (toggle && !IS_ISOCHRONOUS) ? PID_DATA1 : PID_DATA0;
        end
        SEND_DATA: begin
          txValid_o    = data_valid;
          txData_o     = EP_data_i;
          EP_popData_o = accept;
        end
        SEND_EOP: begin
          txEop_o = 1'b1;
          // Isochronous packets have no handshake, so they commit at once.
          if (IS_ISOCHRONOUS) begin
            EP_popTransDone_o    = 1'b1;
            EP_popTransSuccess_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk12_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      toggle       <= 1'b0;
      done_pulse   <= 1'b0;
      success_flag <= 1'b0;
    end else begin
      done_pulse   <= 1'b0;
      success_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (txReq_i) state <= SEND_PID;
        end
        SEND_PID: begin
          if (txReady_i) begin
            state <= SEND_DATA;
            cnt   <= '0;
          end
        end
        SEND_DATA: begin
          if (accept) cnt <= cnt + CNT_W'(1);
          // An empty FIFO or a full packet both end the payload. An empty FIFO
          // on entry gives a zero-length packet.
          if (!EP_dataAvailable_i || !room) state <= SEND_EOP;
        end
        SEND_EOP: begin
          if (IS_ISOCHRONOUS) state <= IDLE;
          else                state <= WAIT_HS;
        end
        WAIT_HS: begin
          // A handshake beats a timeout that lands in the same cycle.
          if (hsValid_i) begin
            done_pulse   <= 1'b1;
            success_flag <= hsIsAck_i;
            if (hsIsAck_i) toggle <= ~toggle;
            state <= IDLE;
          end else if (hsTimeout_i) begin
            done_pulse   <= 1'b1;
            success_flag <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // A configuration toggle reset overrides an ACK flip in the same cycle.
      // It does not disturb a packet that is already in flight.
      if (resetDataToggle_i) toggle <= 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_ep_tx_packetizer.sv
// Testbench for usb_ep_tx_packetizer.
// Instance a: MAX_PACKET_SIZE=64, handshake mode.
// Instance b: MAX_PACKET_SIZE=8, isochronous.
// Each instance is fed by a FIFO emulator that supports commit and rollback.
// A separate reference model tracks the pending bytes and the data toggle.
module tb_usb_ep_tx_packetizer;

  localparam int HS_ACK = 0, HS_NAK = 1, HS_TMO = 2, HS_BOTH = 3, HS_ACKRST = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_req, a_rtog, a_avail, a_pop, a_done, a_succ, a_valid, a_ready, a_eop;
  logic a_hsv, a_hsack, a_tmo, a_busy, a_tog;
  logic [7:0] a_data, a_txd;
  logic b_req, b_rtog, b_avail, b_pop, b_done, b_succ, b_valid, b_ready, b_eop;
  logic b_hsv, b_hsack, b_tmo, b_busy, b_tog;
  logic [7:0] b_data, b_txd;

  usb_ep_tx_packetizer #(.MAX_PACKET_SIZE(64), .IS_ISOCHRONOUS(1'b0)) dut_a (
    .clk12_i(clk), .rst_i(rst), .txReq_i(a_req), .resetDataToggle_i(a_rtog),
    .EP_dataAvailable_i(a_avail), .EP_data_i(a_data), .EP_popData_o(a_pop),
    .EP_popTransDone_o(a_done), .EP_popTransSuccess_o(a_succ),
    .txValid_o(a_valid), .txData_o(a_txd), .txReady_i(a_ready), .txEop_o(a_eop),
    .hsValid_i(a_hsv), .hsIsAck_i(a_hsack), .hsTimeout_i(a_tmo),
    .busy_o(a_busy), .dataToggle_o(a_tog));

  usb_ep_tx_packetizer #(.MAX_PACKET_SIZE(8), .IS_ISOCHRONOUS(1'b1)) dut_b (
    .clk12_i(clk), .rst_i(rst), .txReq_i(b_req), .resetDataToggle_i(b_rtog),
    .EP_dataAvailable_i(b_avail), .EP_data_i(b_data), .EP_popData_o(b_pop),
    .EP_popTransDone_o(b_done), .EP_popTransSuccess_o(b_succ),
    .txValid_o(b_valid), .txData_o(b_txd), .txReady_i(b_ready), .txEop_o(b_eop),
    .hsValid_i(b_hsv), .hsIsAck_i(b_hsack), .hsTimeout_i(b_tmo),
    .busy_o(b_busy), .dataToggle_o(b_tog));

  int n_checks = 0;
  int n_err = 0;

  // FIFO emulators (a_q/b_q with read offsets) and reference models (m_q/mb_q).
  logic [7:0] a_q[$], m_q[$], a_log[$], exp_s[$];
  logic [7:0] b_q[$], mb_q[$], b_log[$], expb_s[$];
  int a_rd = 0, b_rd = 0;
  logic m_tog = 1'b0;
  int a_pops, a_eops, a_dones, b_pops, b_eops, b_dones;

  logic sa_valid, sa_pop, sa_eop, sa_done, sa_succ, sa_busy, sa_tog;
  logic sb_valid, sb_pop, sb_eop, sb_done, sb_succ, sb_busy, sb_tog;
  logic [7:0] sa_data, sb_data;
  logic s_rst;

  typedef struct {
    int         nbytes;
    logic [7:0] base;
    logic [7:0] step;
    int         hs;
    int         stall_at;
    int         stall_len;
    logic [7:0] exp_pid;
    int         exp_pops;
    logic       exp_succ;
    logic       exp_tog;
  } vec_t;
  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void refresh();
    a_avail = (a_rd < a_q.size());
    a_data  = a_avail ? a_q[a_rd] : 8'h00;
    b_avail = (b_rd < b_q.size());
    b_data  = b_avail ? b_q[b_rd] : 8'h00;
  endfunction

  // Samples outputs at the falling edge and lets the DUT clock on the rising
  // edge. It then updates the FIFO emulators from the sampled pop and
  // commit/rollback activity.
  task automatic tick();
    @(negedge clk);
    s_rst = rst;
    sa_valid = a_valid; sa_data = a_txd; sa_pop = a_pop; sa_eop = a_eop;
    sa_done = a_done; sa_succ = a_succ; sa_busy = a_busy; sa_tog = a_tog;
    sb_valid = b_valid; sb_data = b_txd; sb_pop = b_pop; sb_eop = b_eop;
    sb_done = b_done; sb_succ = b_succ; sb_busy = b_busy; sb_tog = b_tog;
    if (a_valid && a_ready) a_log.push_back(a_txd);
    if (a_pop) a_pops++;
    if (a_eop) a_eops++;
    if (a_done) a_dones++;
    if (b_valid && b_ready) b_log.push_back(b_txd);
    if (b_pop) b_pops++;
    if (b_eop) b_eops++;
    if (b_done) b_dones++;
    @(posedge clk);
    #1;
    if (sa_pop) a_rd++;
    if (sa_done) begin
      if (sa_succ) repeat (a_rd) void'(a_q.pop_front());
      a_rd = 0;
    end
    if (sb_pop) b_rd++;
    if (sb_done) begin
      if (sb_succ) repeat (b_rd) void'(b_q.pop_front());
      b_rd = 0;
    end
    if (s_rst) begin a_rd = 0; b_rd = 0; end
    refresh();
  endtask

  task automatic push_a(input logic [7:0] v);
    a_q.push_back(v); m_q.push_back(v); refresh();
  endtask

  task automatic push_b(input logic [7:0] v);
    b_q.push_back(v); mb_q.push_back(v); refresh();
  endtask

  // One full IN transaction on instance a, checked against the reference model.
  task automatic run_txn(input int hs, input int stall_at, input int stall_len,
                         input bit rnd_ready, input string tag,
                         output logic [7:0] pid, output int pops,
                         output logic succ, output logic tog);
    int k, guard, stall_left, mism;
    logic exp_succ;
    logic done_now, busy_now;
    k = (m_q.size() < 64) ? m_q.size() : 64;
    exp_s = {};
    exp_s.push_back(m_tog ? 8'h4B : 8'hC3);
    for (int i = 0; i < k; i++) exp_s.push_back(m_q[i]);
    a_log = {}; a_pops = 0; a_eops = 0; a_dones = 0;
    stall_left = stall_len;
    a_ready = 1'b1; a_req = 1'b1;
    tick();
    a_req = 1'b0;
    guard = 0;
    while (a_eops == 0 && guard < 600) begin
      if (rnd_ready) a_ready = ($urandom_range(0, 3) != 0);
      else if (stall_left > 0 && a_log.size() == stall_at) a_ready = 1'b0;
      else a_ready = 1'b1;
      tick();
      guard++;
      if (!rnd_ready && !a_ready) begin
        stall_left--;
        check({tag, ":stall_valid"}, sa_valid, 1);
        check({tag, ":stall_pop"}, sa_pop, 0);
        if (stall_at < exp_s.size()) check({tag, ":stall_data"}, sa_data, exp_s[stall_at]);
      end
    end
    a_ready = 1'b1;
    check({tag, ":eop_count"}, a_eops, 1);
    case (hs)
      HS_ACK:    begin a_hsv = 1; a_hsack = 1; end
      HS_NAK:    begin a_hsv = 1; a_hsack = 0; end
      HS_TMO:    begin a_tmo = 1; end
      HS_BOTH:   begin a_hsv = 1; a_hsack = 1; a_tmo = 1; end
      default:   begin a_hsv = 1; a_hsack = 1; a_rtog = 1; end
    endcase
    tick();
    check({tag, ":wait_hs_busy"}, sa_busy, 1);
    check({tag, ":no_early_done"}, sa_done, 0);
    a_hsv = 0; a_hsack = 0; a_tmo = 0; a_rtog = 0;
    tick();
    done_now = sa_done; succ = sa_succ; busy_now = sa_busy; tog = sa_tog;
    tick();
    pid = (a_log.size() > 0) ? a_log[0] : 8'h00;
    pops = a_pops;
    mism = 0;
    for (int i = 0; i < exp_s.size(); i++)
      if (i >= a_log.size() || a_log[i] !== exp_s[i]) mism++;
    check({tag, ":stream_len"}, a_log.size(), exp_s.size());
    check({tag, ":stream_bytes"}, mism, 0);
    check({tag, ":pops"}, a_pops, k);
    exp_succ = (hs == HS_ACK || hs == HS_BOTH || hs == HS_ACKRST);
    if (exp_succ) begin
      repeat (k) void'(m_q.pop_front());
      m_tog = ~m_tog;
    end
    if (hs == HS_ACKRST) m_tog = 1'b0;
    check({tag, ":done_pulse"}, done_now, 1);
    check({tag, ":single_done"}, a_dones, 1);
    check({tag, ":success"}, succ, exp_succ);
    check({tag, ":toggle"}, tog, m_tog);
    check({tag, ":idle_after"}, busy_now, 0);
  endtask

  // One isochronous transaction on instance b. The handshake inputs are held
  // active throughout and must be ignored.
  task automatic run_iso(input string tag);
    int k, guard, mism;
    k = (mb_q.size() < 8) ? mb_q.size() : 8;
    expb_s = {};
    expb_s.push_back(8'hC3);
    for (int i = 0; i < k; i++) expb_s.push_back(mb_q[i]);
    b_log = {}; b_pops = 0; b_eops = 0; b_dones = 0;
    b_req = 1'b1;
    tick();
    b_req = 1'b0;
    guard = 0;
    while (b_eops == 0 && guard < 200) begin
      tick();
      guard++;
      if (sb_eop) begin
        check({tag, ":done_at_eop"}, sb_done, 1);
        check({tag, ":succ_at_eop"}, sb_succ, 1);
      end
    end
    check({tag, ":eop_count"}, b_eops, 1);
    tick();
    tick();
    check({tag, ":idle_after"}, sb_busy, 0);
    check({tag, ":single_done"}, b_dones, 1);
    check({tag, ":toggle"}, sb_tog, 0);
    check({tag, ":pops"}, b_pops, k);
    mism = 0;
    for (int i = 0; i < expb_s.size(); i++)
      if (i >= b_log.size() || b_log[i] !== expb_s[i]) mism++;
    check({tag, ":stream_len"}, b_log.size(), expb_s.size());
    check({tag, ":stream_bytes"}, mism, 0);
    repeat (k) void'(mb_q.pop_front());
  endtask

  initial begin
    logic [7:0] pid;
    int pops, guard, n;
    logic succ, tog;

    vt[0] = '{3,  8'h11, 8'h11, HS_ACK,    -1, 0, 8'hC3, 3,  1'b1, 1'b1};
    vt[1] = '{3,  8'h11, 8'h11, HS_ACK,    -1, 0, 8'h4B, 3,  1'b1, 1'b0};
    vt[2] = '{0,  8'h00, 8'h00, HS_ACK,    -1, 0, 8'hC3, 0,  1'b1, 1'b1};
    vt[3] = '{70, 8'h00, 8'h01, HS_ACK,    -1, 0, 8'h4B, 64, 1'b1, 1'b0};
    vt[4] = '{0,  8'h00, 8'h00, HS_ACK,    -1, 0, 8'hC3, 6,  1'b1, 1'b1};
    vt[5] = '{4,  8'hA0, 8'h05, HS_NAK,     2, 3, 8'h4B, 4,  1'b0, 1'b1};
    vt[6] = '{0,  8'h00, 8'h00, HS_BOTH,   -1, 0, 8'h4B, 4,  1'b1, 1'b0};
    vt[7] = '{2,  8'h5A, 8'h11, HS_TMO,    -1, 0, 8'hC3, 2,  1'b0, 1'b0};
    vt[8] = '{0,  8'h00, 8'h00, HS_ACK,    -1, 0, 8'hC3, 2,  1'b1, 1'b1};
    vt[9] = '{1,  8'hE7, 8'h00, HS_ACKRST, -1, 0, 8'h4B, 1,  1'b1, 1'b0};

    rst = 1'b1;
    a_req = 0; a_rtog = 0; a_ready = 1; a_hsv = 0; a_hsack = 0; a_tmo = 0;
    b_req = 0; b_rtog = 0; b_ready = 1; b_hsv = 0; b_hsack = 0; b_tmo = 0;
    refresh();
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset:txValid", sa_valid, 0);
    check("reset:txData", sa_data, 8'h00);
    check("reset:pop", sa_pop, 0);
    check("reset:eop", sa_eop, 0);
    check("reset:done", sa_done, 0);
    check("reset:success", sa_succ, 0);
    check("reset:busy", sa_busy, 0);
    check("reset:toggle", sa_tog, 0);
    check("reset:iso_busy", sb_busy, 0);

    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < vt[i].nbytes; j++) push_a(vt[i].base + vt[i].step * 8'(j));
      run_txn(vt[i].hs, vt[i].stall_at, vt[i].stall_len, 1'b0, $sformatf("vec%0d", i),
              pid, pops, succ, tog);
      check($sformatf("vec%0d:pid", i), pid, vt[i].exp_pid);
      check($sformatf("vec%0d:pop_count", i), pops, vt[i].exp_pops);
      check($sformatf("vec%0d:tbl_success", i), succ, vt[i].exp_succ);
      check($sformatf("vec%0d:tbl_toggle", i), tog, vt[i].exp_tog);
      if (i == 3) check("vec3:leftover", a_q.size(), 6);
    end

    // Reset in the middle of the payload must not emit a done pulse.
    for (int j = 0; j < 5; j++) push_a(8'h70 + 8'(j));
    a_dones = 0;
    a_req = 1'b1;
    tick();
    a_req = 1'b0;
    guard = 0;
    sa_pop = 1'b0;
    while (!sa_pop && guard < 20) begin tick(); guard++; end
    check("rst_mid:in_data", sa_pop, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rst_mid:busy", sa_busy, 0);
    check("rst_mid:txValid", sa_valid, 0);
    check("rst_mid:txData", sa_data, 8'h00);
    check("rst_mid:pop", sa_pop, 0);
    check("rst_mid:eop", sa_eop, 0);
    check("rst_mid:done_none", a_dones, 0);
    check("rst_mid:toggle", sa_tog, 0);
    m_tog = 1'b0;

    // Randomized transactions checked against the reference model.
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        a_rtog = 1'b1;
        tick();
        a_rtog = 1'b0;
        m_tog = 1'b0;
      end
      n = $urandom_range(0, 80);
      for (int j = 0; j < n; j++) push_a(8'($urandom));
      run_txn($urandom_range(0, 4), -1, 0, 1'b1, $sformatf("rnd%0d", t), pid, pops, succ, tog);
    end

    // Isochronous instance: handshake inputs held active and ignored.
    b_hsv = 1'b1; b_hsack = 1'b0; b_tmo = 1'b1;
    push_b(8'h01); push_b(8'h02); push_b(8'h03);
    run_iso("iso0");
    for (int j = 0; j < 10; j++) push_b(8'h90 + 8'(j));
    run_iso("iso1");
    check("iso1:leftover", b_q.size(), 2);
    run_iso("iso2");
    b_hsv = 1'b0; b_tmo = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
